// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared types and constants for the clock time-setting
// sequencer.
//   state_t           : sequencer states RUN, SET_HR, SET_MIN, SET_SEC
//   FIELD_*           : display field-select encodings
//   TIMEOUT_S_DEFAULT : default idle seconds before a SET state returns to RUN
//   field_of()        : maps a state to its field-select code
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HR   = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  localparam int unsigned TIMEOUT_S_DEFAULT = 30;

  function automatic logic [1:0] field_of(input state_t s);
    logic [1:0] f;
    f = FIELD_NONE;
    case (s)
      SET_HR:  f = FIELD_HR;
      SET_MIN: f = FIELD_MIN;
      SET_SEC: f = FIELD_SEC;
      default: f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_rise_detect.sv
// rise_detect: one-cycle rising-edge detector for an already synchronized
// level.
//   clk  : sampling clock
//   rst  : asynchronous, active-high reset
//   sig  : synchronized input level
//   rise : high while sig is high and was low on the previous edge
// The first edge after reset never reports a rise: a level already high when
// reset releases is a held button, not a new press.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;
  logic armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      sig_q <= sig;
      armed <= 1'b1;
    end
  end

  assign rise = sig & ~sig_q & armed;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting sequencer for the digital clock.
//   TIMEOUT_S   : idle seconds in a SET state before returning to RUN (2..63)
//   seconds_clk : 1 Hz clock, all state changes on its rising edge
//   rst         : asynchronous, active-high reset
//   mode_btn    : synchronized mode button; each press steps
//                 RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
//   inc_btn     : synchronized increment button, level-sensitive
//   run         : high in RUN, enables normal carry counting
//   hr_set / min_set / sec_set : one-per-second increment strobes
//   field_sel   : 00 none, 01 hours, 10 minutes, 11 seconds
//   blink       : toggles each second while a field is being set
// Optional feature: define CLOCK_SET_TIMEOUT_EN to add the idle timeout that
// returns a SET state to RUN after TIMEOUT_S idle seconds.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
  input  logic       seconds_clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic       run,
  output logic       hr_set,
  output logic       min_set,
  output logic       sec_set,
  output logic [1:0] field_sel,
  output logic       blink
);

  if (TIMEOUT_S < 2 || TIMEOUT_S > 63) begin : g_bad_timeout
    $error("clock_set_ctrl: TIMEOUT_S must be in 2..63");
  end

  state_t     state;
  state_t     state_nxt;
  logic [2:0] strobe_nxt;   // {hr, min, sec}
  logic       blink_nxt;
  logic       mode_edge;
  logic       timeout;

  rise_detect u_mode_rise (
    .clk  (seconds_clk),
    .rst  (rst),
    .sig  (mode_btn),
    .rise (mode_edge)
  );

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT_S - 1);

  logic [5:0] idle_cnt;
  logic [5:0] idle_nxt;

  assign timeout = (state != RUN) && !inc_btn && (idle_cnt == IDLE_LAST);

  // Any activity, any state change into SET and every RUN cycle restart the
  // idle count, so it only advances across consecutive idle SET seconds.
  always_comb begin
    idle_nxt = idle_cnt + 6'd1;
    if (mode_edge || inc_btn || state_nxt == RUN) idle_nxt = '0;
  end

  always_ff @(posedge seconds_clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else     idle_cnt <= idle_nxt;
  end
`else
  assign timeout = 1'b0;
`endif

  // Priority: mode press, then increment, then timeout.
  always_comb begin
    state_nxt  = state;
    strobe_nxt = '0;
    if (mode_edge) begin
      case (state)
        RUN:     state_nxt = SET_HR;
        SET_HR:  state_nxt = SET_MIN;
        SET_MIN: state_nxt = SET_SEC;
        default: state_nxt = RUN;
      endcase
    end else if (state != RUN && inc_btn) begin
      case (state)
        SET_HR:  strobe_nxt = 3'b100;
        SET_MIN: strobe_nxt = 3'b010;
        default: strobe_nxt = 3'b001;
      endcase
    end else if (timeout) begin
      state_nxt = RUN;
    end
  end

  // Blink restarts low when leaving RUN and keeps its phase across
  // field-to-field moves.
  always_comb begin
    blink_nxt = ~blink;
    if (state_nxt == RUN || state == RUN) blink_nxt = 1'b0;
  end

  always_ff @(posedge seconds_clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      run       <= 1'b1;
      hr_set    <= 1'b0;
      min_set   <= 1'b0;
      sec_set   <= 1'b0;
      field_sel <= FIELD_NONE;
      blink     <= 1'b0;
    end else begin
      state     <= state_nxt;
      run       <= (state_nxt == RUN);
      hr_set    <= strobe_nxt[2];
      min_set   <= strobe_nxt[1];
      sec_set   <= strobe_nxt[0];
      field_sel <= field_of(state_nxt);
      blink     <= blink_nxt;
    end
  end

endmodule
